// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, 1-cycle-latency imem reads, prefetch queue.
// Optional `FETCH_BYPASS_EN forwards a response straight to the output when the queue is empty.
module fetch_unit #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_inflight_addr;
  logic               r_inflight;
  logic [INSTR_W-1:0] r_q_instr [DEPTH];
  logic [ADDR_W-1:0]  r_q_pc    [DEPTH];
  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [CW-1:0]      r_count;

  logic               w_resp;
  logic               w_bypass;
  logic               w_pop;
  logic               w_q_pop;
  logic               w_push;
  logic [CW-1:0]      w_occ;

  // A response arriving in a redirect cycle is killed.
  assign w_resp = r_inflight & ~redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_resp & (r_count == '0);
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    out_valid = (r_count != '0) | w_bypass;
    out_instr = r_q_instr[r_head];
    out_pc    = r_q_pc[r_head];
    if (w_bypass) begin
      out_instr = imem_rdata;
      out_pc    = r_inflight_addr;
    end
  end

  assign w_pop   = out_valid & out_ready;
  assign w_q_pop = w_pop & ~w_bypass;
  assign w_push  = w_resp & ~(w_bypass & out_ready);

  // Entries held or promised after this cycle; a new request needs a free slot.
  assign w_occ     = r_count + CW'(r_inflight) - CW'(w_pop);
  assign imem_en   = reset & ~redirect_valid & (w_occ < CW'(DEPTH));
  assign imem_addr = r_fetch_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc      <= RESET_PC;
      r_inflight      <= 1'b0;
      r_inflight_addr <= RESET_PC;
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_addr;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= imem_en;
      if (imem_en) begin
        r_fetch_pc      <= r_fetch_pc + 1'b1;
        r_inflight_addr <= r_fetch_pc;
      end
      if (w_push) begin
        r_q_instr[r_tail] <= imem_rdata;
        r_q_pc[r_tail]    <= r_inflight_addr;
        r_tail            <= r_tail + 1'b1;
      end
      if (w_q_pop) begin
        r_head <= r_head + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_q_pop);
    end
  end

endmodule
